cyber_match_sequencer: RTL

Round and match controller for the Cyber War tug-of-war game. It sequences the playfield through serve, play and point phases, and keeps each side's point score. It also adapts the cyber player's difficulty threshold after every point. It sits between the user inputs/divided clock and the playfield, cyber-player comparator and score displays.

---
 rtl/cyber_match_sequencer_pkg.sv | 29 ++
 rtl/cyber_match_sequencer_hold_timer.sv | 27 ++
 rtl/cyber_match_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cyber_match_sequencer_pkg.sv
// Shared types, constants and difficulty-adaptation rule for the Cyber War match sequencer.
package cyber_pkg;

  localparam int unsigned DIFF_W  = 9;
  localparam int unsigned SCORE_W = 3;
  localparam logic [DIFF_W-1:0] DIFF_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    DONE  = 3'd4
  } match_state_t;

  // Human point doubles (+1) up to all-ones; cyber point halves with a floor of 1.
  function automatic logic [DIFF_W-1:0] next_difficulty(input logic [DIFF_W-1:0] cur,
                                                        input logic              human_won);
    logic [DIFF_W-1:0] res;
    if (human_won) begin
      res = cur[DIFF_W-1] ? DIFF_MAX : {cur[DIFF_W-2:0], 1'b1};
    end else begin
      res = cur >> 1;
      if (res == '0) res = DIFF_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/cyber_match_sequencer_hold_timer.sv
// Loadable down-counter with zero flag, timing the SERVE and POINT holds.
module hold_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/cyber_match_sequencer.sv
// Cyber War match controller: serve/play/point sequencing, scoring and adaptive difficulty.
module cyber_match_sequencer
  import cyber_pkg::*;
#(
  parameter int unsigned        WIN_POINTS  = 7,
  parameter int unsigned        HOLD_CYCLES = 16,
  parameter int unsigned        DIFF_W      = 9,
  parameter logic [DIFF_W-1:0]  DIFF_INIT   = 9'd7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              win_L,
  input  logic              win_R,
  output logic              field_reset,
  output logic              play_en,
  output logic [DIFF_W-1:0] difficulty,
  output logic [2:0]        score_L,
  output logic [2:0]        score_R,
  output logic              match_over,
  output logic              winner_R
);

  localparam int unsigned PKG_DIFF_W = cyber_pkg::DIFF_W;
  localparam int unsigned CNT_W      = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WIN_POINTS);

  match_state_t        state_q, state_d;
  logic [SCORE_W-1:0]  score_l_q, score_l_d;
  logic [SCORE_W-1:0]  score_r_q, score_r_d;
  logic [DIFF_W-1:0]   diff_q, diff_d;
  logic                winner_q, winner_d;
  logic                start_q;
  logic                start_edge_c;
  logic                tmr_load_c;
  logic                tmr_zero_c;

  assign start_edge_c = start & ~start_q;

  hold_timer #(.CNT_W(CNT_W)) u_hold_timer (
    .clk      (clk),
    .rst      (reset),
    .load     (tmr_load_c),
    .load_val (HOLD_LOAD),
    .zero_c   (tmr_zero_c)
  );

  // Next-state, score/difficulty update and Moore output decode.
  always_comb begin
    state_d     = state_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    diff_d      = diff_q;
    winner_d    = winner_q;
    tmr_load_c  = 1'b0;
    field_reset = 1'b0;
    play_en     = 1'b0;
    match_over  = 1'b0;

    case (state_q)
      IDLE: begin
        field_reset = 1'b1;
        if (start_edge_c) begin
          score_l_d  = '0;
          score_r_d  = '0;
          diff_d     = DIFF_INIT;
          tmr_load_c = 1'b1;
          state_d    = SERVE;
        end
      end
      SERVE: begin
        field_reset = 1'b1;
        if (tmr_zero_c) state_d = PLAY;
      end
      PLAY: begin
        play_en = 1'b1;
        if (win_L && win_R) begin
          tmr_load_c = 1'b1;
          state_d    = SERVE;
        end else if (win_L) begin
          if (score_l_q < WIN_SCORE) score_l_d = score_l_q + SCORE_W'(1);
          diff_d     = DIFF_W'(next_difficulty(PKG_DIFF_W'(diff_q), 1'b0));
          tmr_load_c = 1'b1;
          state_d    = POINT;
        end else if (win_R) begin
          if (score_r_q < WIN_SCORE) score_r_d = score_r_q + SCORE_W'(1);
          diff_d     = DIFF_W'(next_difficulty(PKG_DIFF_W'(diff_q), 1'b1));
          tmr_load_c = 1'b1;
          state_d    = POINT;
        end
      end
      POINT: begin
        if (tmr_zero_c) begin
          if (score_l_q == WIN_SCORE || score_r_q == WIN_SCORE) begin
            winner_d = (score_r_q == WIN_SCORE);
            state_d  = DONE;
          end else begin
            tmr_load_c = 1'b1;
            state_d    = SERVE;
          end
        end
      end
      DONE: begin
        match_over = 1'b1;
        if (start_edge_c) state_d = IDLE;
      end
      default: begin
        field_reset = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // start edge register resets high so a start held through reset is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      score_l_q <= '0;
      score_r_q <= '0;
      diff_q    <= DIFF_INIT;
      winner_q  <= 1'b0;
      start_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      diff_q    <= diff_d;
      winner_q  <= winner_d;
      start_q   <= start;
    end
  end

  assign difficulty = diff_q;
  assign score_L    = score_l_q;
  assign score_R    = score_r_q;
  assign winner_R   = winner_q;

endmodule
